prau_result_buffer: RTL

Decoupling result queue directly downstream of the posit/quire arithmetic unit top level. It accepts completed results and their tags from the unit's output valid/ready handshake. It stores up to DEPTH of them in order and presents them to the core writeback port through a second valid/ready handshake. The core can therefore stall writeback without back-pressuring the arithmetic unit, until the buffer is full.

---
 rtl/prau_pkg.sv | 18 +
 rtl/prau_result_buffer.sv | 118 +++++++++++
 2 files changed

// File: rtl/prau_pkg.sv
// -----------------------------------------------------------------------------
// prau_pkg
// Shared constants and helpers for the posit/quire arithmetic unit (PRAU)
// integration. The top-level integration passes PRAU_RESULT_BUF_DEPTH to
// prau_result_buffer as its DEPTH parameter.
// -----------------------------------------------------------------------------
package prau_pkg;

   // Number of completed results that can queue between the arithmetic unit
   // and the core writeback port before the unit sees back-pressure.
   localparam int unsigned PRAU_RESULT_BUF_DEPTH = 4;

   // True when n is a power of two (n > 0).
   function automatic bit prau_is_pow2(input int unsigned n);
      return (n != 0) && ((n & (n - 1)) == 0);
   endfunction

endpackage : prau_pkg

// File: rtl/prau_result_buffer.sv
// -----------------------------------------------------------------------------
// prau_result_buffer
// In-order result queue between the PRAU output handshake and the core
// writeback port, so that a writeback stall does not back-pressure the
// arithmetic unit until DEPTH results are waiting.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   flush_i                synchronous flush, discards all stored entries
//   in_valid_i/in_ready_o  input handshake from the arithmetic unit
//   in_tag_i, in_result_i  incoming tag and result
//   out_valid_o/out_ready_i output handshake toward the core writeback
//   out_tag_o, out_result_o head entry (stale/don't-care while empty)
//   count_o                number of stored entries
//   empty_o, full_o        occupancy flags
// -----------------------------------------------------------------------------
module prau_result_buffer
   import prau_pkg::*;
#(
   parameter int unsigned XLEN  = 64,
   parameter int unsigned DEPTH = PRAU_RESULT_BUF_DEPTH,
   parameter type         tag_t = logic
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         flush_i,
   input  logic                         in_valid_i,
   output logic                         in_ready_o,
   input  tag_t                         in_tag_i,
   input  logic [XLEN-1:0]              in_result_i,
   output logic                         out_valid_o,
   input  logic                         out_ready_i,
   output tag_t                         out_tag_o,
   output logic [XLEN-1:0]              out_result_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o,
   output logic                         empty_o,
   output logic                         full_o
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = $clog2(DEPTH + 1);
   localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

   generate
      if (!prau_is_pow2(DEPTH) || (DEPTH < 2)) begin : g_depth_check
         $error("prau_result_buffer: DEPTH must be a power of two and >= 2");
      end
   endgenerate

   typedef struct packed {
      tag_t            tag;
      logic [XLEN-1:0] result;
   } entry_t;

   entry_t          mem_q [DEPTH];
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            push, pop;

   assign empty_o     = (cnt_q == '0);
   assign full_o      = (cnt_q == CntFull);
   assign count_o     = cnt_q;
   // Ready deliberately ignores out_ready_i: a slot freed by a pop is only
   // offered from the following cycle, keeping the two handshakes decoupled.
   assign in_ready_o  = ~full_o & ~flush_i;
   assign out_valid_o = ~empty_o;

   assign push = in_valid_i & in_ready_o;
   assign pop  = out_valid_o & out_ready_i;

   assign out_tag_o    = mem_q[rd_ptr_q].tag;
   assign out_result_o = mem_q[rd_ptr_q].result;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage is not touched by flush, only by reset and pushes.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else if (push) begin
         mem_q[wr_ptr_q] <= '{tag: in_tag_i, result: in_result_i};
      end
   end

endmodule : prau_result_buffer
